// File: rtl/msa_pkg.sv
// Shared constants, FSM state encoding and slot-entry layout for the matrix slot allocator.
package msa_pkg;

  localparam int SLOT_WORDS = 25;
  localparam int MAX_DIM    = 5;
  localparam int ADDR_W     = 9;
  localparam int STAMP_BITS = 16;

  typedef enum logic [2:0] {
    IDLE,
    A_SCAN,
    DECIDE,
    WAIT_COMMIT,
    FAIL_HOLD,
    Q_SCAN,
    Q_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_SET_PEND,
    OP_COMMIT,
    OP_RELEASE,
    OP_INVALIDATE
  } wr_op_t;

  typedef struct packed {
    logic                  valid;
    logic                  pend;
    logic [2:0]            m;
    logic [2:0]            n;
    logic [STAMP_BITS-1:0] stamp;
  } slot_t;

endpackage

// File: rtl/msa_slot_table.sv
// Per-slot register array: one combinational read port at the scan index, one write port.
module msa_slot_table
  import msa_pkg::*;
#(
  parameter int SLOTS = 20,
  parameter int IDX_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IDX_W-1:0]      rd_idx,
  output slot_t                 rd_entry,
  input  logic                  wr_en,
  input  wr_op_t                wr_op,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [2:0]            wr_m,
  input  logic [2:0]            wr_n,
  input  logic [STAMP_BITS-1:0] wr_stamp
);

  logic [SLOTS-1:0]      valid_q;
  logic [SLOTS-1:0]      pend_q;
  logic [2:0]            m_q     [SLOTS];
  logic [2:0]            n_q     [SLOTS];
  logic [STAMP_BITS-1:0] stamp_q [SLOTS];

  // Only the valid/pend flags need clearing; dims and stamps are ignored while a slot is free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      pend_q  <= '0;
    end else if (wr_en) begin
      case (wr_op)
        OP_SET_PEND: begin
          valid_q[wr_idx] <= 1'b0;
          pend_q[wr_idx]  <= 1'b1;
        end
        OP_COMMIT: begin
          valid_q[wr_idx] <= 1'b1;
          pend_q[wr_idx]  <= 1'b0;
        end
        OP_RELEASE: begin
          valid_q[wr_idx] <= 1'b0;
          pend_q[wr_idx]  <= 1'b0;
        end
        default: valid_q[wr_idx] <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && wr_op == OP_SET_PEND) begin
      m_q[wr_idx] <= wr_m;
      n_q[wr_idx] <= wr_n;
    end
    if (wr_en && wr_op == OP_COMMIT) begin
      stamp_q[wr_idx] <= wr_stamp;
    end
  end

  always_comb begin
    rd_entry.valid = valid_q[rd_idx];
    rd_entry.pend  = pend_q[rd_idx];
    rd_entry.m     = m_q[rd_idx];
    rd_entry.n     = n_q[rd_idx];
    rd_entry.stamp = stamp_q[rd_idx];
  end

endmodule

// File: rtl/matrix_slot_allocator.sv
// Matrix storage slot allocator: serial scan/decide FSM for allocation plus (m,n,id) lookup.
// Build option MSA_GLOBAL_EVICT_EN: with no free slot, evict the globally oldest valid slot.
module matrix_slot_allocator #(
  parameter int SLOTS       = 20,
  parameter int SLOT_WORDS  = 25,
  parameter int MAX_PER_DIM = 2,
  parameter int STAMP_W     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alloc_req,
  input  logic [2:0] alloc_m,
  input  logic [2:0] alloc_n,
  output logic       addr_ready,
  output logic [8:0] base_addr,
  output logic       alloc_fail,
  input  logic       commit,
  input  logic       abort,
  input  logic       q_req,
  input  logic [2:0] q_m,
  input  logic [2:0] q_n,
  input  logic [2:0] q_id,
  output logic       q_done,
  output logic       q_hit,
  output logic [8:0] q_base,
  output logic [2:0] q_count,
  output logic       busy
);
  import msa_pkg::*;

  localparam int IDX_W = $clog2(SLOTS + 1);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, victim_q, victim, old_idx_q, free_idx_q;
  logic [IDX_W-1:0]     cnt_q, cnt_nx, run;
  logic [2:0]           m_q, n_q, id_q;
  logic [STAMP_W-1:0]   seq_q, old_age_q, age;
  logic                 old_found_q, free_found_q, hit_acc_q, hit_now, hit_nx;
  logic [ADDR_W-1:0]    hbase_q, hbase_nx;
  logic                 match, last, grant, fail;
  slot_t                entry;
  logic                 wr_en;
  wr_op_t               wr_op;
  logic [IDX_W-1:0]     wr_idx;

  function automatic logic [ADDR_W-1:0] base_of(input logic [IDX_W-1:0] i);
    return ADDR_W'(i) * ADDR_W'(SLOT_WORDS);
  endfunction

  function automatic logic dim_ok(input logic [2:0] d);
    return (d != 3'd0) && (d <= 3'(MAX_DIM));
  endfunction

  function automatic logic [2:0] sat3(input logic [IDX_W-1:0] c);
    return (c > IDX_W'(7)) ? 3'd7 : c[2:0];
  endfunction

  msa_slot_table #(.SLOTS(SLOTS), .IDX_W(IDX_W)) u_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (idx_q),
    .rd_entry (entry),
    .wr_en    (wr_en),
    .wr_op    (wr_op),
    .wr_idx   (wr_idx),
    .wr_m     (m_q),
    .wr_n     (n_q),
    .wr_stamp (STAMP_BITS'(seq_q))
  );

  assign busy     = (state_q != IDLE);
  assign match    = entry.valid && (entry.m == m_q) && (entry.n == n_q);
  assign age      = seq_q - entry.stamp[STAMP_W-1:0];
  assign last     = (idx_q == IDX_W'(SLOTS - 1));
  assign run      = cnt_q + 1'b1;
  assign cnt_nx   = match ? run : cnt_q;
  assign hit_now  = (state_q == Q_SCAN) && match && !hit_acc_q && (run == IDX_W'(id_q));
  assign hit_nx   = hit_acc_q | hit_now;
  assign hbase_nx = hit_now ? base_of(idx_q) : hbase_q;

`ifdef MSA_GLOBAL_EVICT_EN
  logic                 glob_found_q;
  logic [IDX_W-1:0]     glob_idx_q;
  logic [STAMP_W-1:0]   glob_age_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glob_found_q <= 1'b0;
      glob_idx_q   <= '0;
      glob_age_q   <= '0;
    end else if (state_q == IDLE) begin
      glob_found_q <= 1'b0;
    end else if (state_q == A_SCAN && entry.valid && (!glob_found_q || age > glob_age_q)) begin
      glob_found_q <= 1'b1;
      glob_idx_q   <= idx_q;
      glob_age_q   <= age;
    end
  end
`endif

  // Victim selection from the accumulated scan results.
  always_comb begin
    grant  = 1'b0;
    fail   = 1'b0;
    victim = free_idx_q;
    if (!dim_ok(m_q) || !dim_ok(n_q)) begin
      fail = 1'b1;
    end else if (cnt_q >= IDX_W'(MAX_PER_DIM)) begin
      grant  = 1'b1;
      victim = old_idx_q;
    end else if (free_found_q) begin
      grant  = 1'b1;
      victim = free_idx_q;
    end
`ifdef MSA_GLOBAL_EVICT_EN
    else if (glob_found_q) begin
      grant  = 1'b1;
      victim = glob_idx_q;
    end
`endif
    else begin
      fail = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    wr_op   = OP_SET_PEND;
    wr_idx  = victim_q;
    case (state_q)
      IDLE: begin
        if (alloc_req)  state_d = A_SCAN;
        else if (q_req) state_d = Q_SCAN;
      end
      A_SCAN: if (last) state_d = DECIDE;
      DECIDE: begin
        if (grant) begin
          state_d = WAIT_COMMIT;
          wr_en   = 1'b1;
          wr_idx  = victim;
        end else begin
          state_d = FAIL_HOLD;
        end
      end
      WAIT_COMMIT: begin
        if (abort) begin
          state_d = IDLE;
          wr_en   = 1'b1;
          wr_op   = OP_RELEASE;
        end else if (commit) begin
          state_d = IDLE;
          wr_en   = 1'b1;
          wr_op   = OP_COMMIT;
        end
      end
      FAIL_HOLD: if (!alloc_req) state_d = IDLE;
      Q_SCAN:    if (last) state_d = Q_DONE;
      Q_DONE:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      cnt_q        <= '0;
      m_q          <= '0;
      n_q          <= '0;
      id_q         <= '0;
      seq_q        <= '0;
      old_found_q  <= 1'b0;
      old_idx_q    <= '0;
      old_age_q    <= '0;
      free_found_q <= 1'b0;
      free_idx_q   <= '0;
      hit_acc_q    <= 1'b0;
      hbase_q      <= '0;
      victim_q     <= '0;
      addr_ready   <= 1'b0;
      base_addr    <= '0;
      alloc_fail   <= 1'b0;
      q_done       <= 1'b0;
      q_hit        <= 1'b0;
      q_base       <= '0;
      q_count      <= '0;
    end else begin
      addr_ready <= 1'b0;
      alloc_fail <= 1'b0;
      q_done     <= 1'b0;
      case (state_q)
        IDLE: begin
          idx_q        <= '0;
          cnt_q        <= '0;
          old_found_q  <= 1'b0;
          free_found_q <= 1'b0;
          hit_acc_q    <= 1'b0;
          hbase_q      <= '0;
          if (alloc_req) begin
            m_q <= alloc_m;
            n_q <= alloc_n;
          end else if (q_req) begin
            m_q  <= q_m;
            n_q  <= q_n;
            id_q <= q_id;
          end
        end
        A_SCAN, Q_SCAN: begin
          idx_q     <= idx_q + 1'b1;
          cnt_q     <= cnt_nx;
          hit_acc_q <= hit_nx;
          hbase_q   <= hbase_nx;
          if (state_q == A_SCAN && match && (!old_found_q || age > old_age_q)) begin
            old_found_q <= 1'b1;
            old_idx_q   <= idx_q;
            old_age_q   <= age;
          end
          if (state_q == A_SCAN && !entry.valid && !entry.pend && !free_found_q) begin
            free_found_q <= 1'b1;
            free_idx_q   <= idx_q;
          end
          if (state_q == Q_SCAN && last) begin
            q_done  <= 1'b1;
            q_hit   <= hit_nx;
            q_base  <= hbase_nx;
            q_count <= sat3(cnt_nx);
          end
        end
        DECIDE: begin
          if (grant) begin
            addr_ready <= 1'b1;
            base_addr  <= base_of(victim);
            victim_q   <= victim;
          end else begin
            alloc_fail <= 1'b1;
          end
        end
        WAIT_COMMIT: if (!abort && commit) seq_q <= seq_q + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_slot_allocator.sv
// Bench for matrix_slot_allocator: vector table plus hand sequences, scoreboard-checked.
module tb_matrix_slot_allocator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       alloc_req = 1'b0;
  logic [2:0] alloc_m = '0, alloc_n = '0;
  logic       addr_ready, alloc_fail, q_done, q_hit, busy;
  logic [8:0] base_addr, q_base;
  logic [2:0] q_count;
  logic       commit = 1'b0, abort = 1'b0, q_req = 1'b0;
  logic [2:0] q_m = '0, q_n = '0, q_id = '0;

  matrix_slot_allocator dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_req(alloc_req), .alloc_m(alloc_m), .alloc_n(alloc_n),
    .addr_ready(addr_ready), .base_addr(base_addr), .alloc_fail(alloc_fail),
    .commit(commit), .abort(abort),
    .q_req(q_req), .q_m(q_m), .q_n(q_n), .q_id(q_id),
    .q_done(q_done), .q_hit(q_hit), .q_base(q_base), .q_count(q_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_q;
    bit ok;
    int base;
    bit hit;
    int cnt;
  } exp_t;

  typedef struct {
    bit         is_q;
    logic [2:0] m;
    logic [2:0] n;
    logic [2:0] id;
    int         fin;   // 0 commit, 1 abort
    bit         ok;
    int         base;
    bit         hit;
    int         cnt;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[14];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: got event expected none", name);
  endtask

  always @(negedge clk) begin
    if (rst_n && (addr_ready || alloc_fail || q_done)) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_event");
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.is_q) begin
          chk("q_done", q_done, 1);
          chk("q_hit", q_hit, mon_e.hit);
          chk("q_base", q_base, mon_e.base);
          chk("q_count", q_count, mon_e.cnt);
        end else begin
          chk("addr_ready", addr_ready, mon_e.ok);
          chk("alloc_fail", alloc_fail, !mon_e.ok);
          if (mon_e.ok) chk("base_addr", base_addr, mon_e.base);
        end
      end
    end
  end

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_addr_ready"}, addr_ready, 0);
    chk({tag, "_base_addr"}, base_addr, 0);
    chk({tag, "_alloc_fail"}, alloc_fail, 0);
    chk({tag, "_q_done"}, q_done, 0);
    chk({tag, "_q_hit"}, q_hit, 0);
    chk({tag, "_q_base"}, q_base, 0);
    chk({tag, "_q_count"}, q_count, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 10 && busy; c++) @(negedge clk);
    chk("idle", busy, 0);
  endtask

  // fin: 0 commit, 1 abort, 2 leave pending. with_q pulses q_req alongside the request.
  task automatic run_alloc(input logic [2:0] m, input logic [2:0] n, input int fin,
                           input bit with_q, input bit ok, input int base);
    int lat;
    bit seen;
    exp_q.push_back('{is_q: 1'b0, ok: ok, base: base, hit: 1'b0, cnt: 0});
    alloc_m = m;
    alloc_n = n;
    alloc_req = 1'b1;
    if (with_q) begin
      q_m = 3'd1; q_n = 3'd1; q_id = 3'd1; q_req = 1'b1;
    end
    seen = 1'b0;
    lat = 0;
    for (int c = 1; c <= 60 && !seen; c++) begin
      @(negedge clk);
      q_req = 1'b0;
      if (addr_ready || alloc_fail) begin
        seen = 1'b1;
        lat = c;
      end
    end
    chk("grant_latency", lat, 22);
    alloc_req = 1'b0;
    if (seen && addr_ready && fin != 2) begin
      if (fin == 1) abort = 1'b1;
      else commit = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      commit = 1'b0;
    end
    if (fin != 2) wait_idle();
  endtask

  task automatic run_query(input logic [2:0] m, input logic [2:0] n, input logic [2:0] id,
                           input bit hit, input int base, input int cnt);
    bit seen;
    exp_q.push_back('{is_q: 1'b1, ok: 1'b0, base: base, hit: hit, cnt: cnt});
    q_m = m;
    q_n = n;
    q_id = id;
    q_req = 1'b1;
    @(negedge clk);
    q_req = 1'b0;
    seen = q_done;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      seen = q_done;
    end
    chk("q_seen", seen, 1);
    wait_idle();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //           is_q m  n  id fin ok base hit cnt
    vecs[0]  = '{0, 2, 3, 0, 0, 1, 0,  0, 0};
    vecs[1]  = '{1, 2, 3, 1, 0, 0, 0,  1, 1};
    vecs[2]  = '{0, 2, 3, 0, 0, 1, 25, 0, 0};
    vecs[3]  = '{0, 2, 3, 0, 0, 1, 0,  0, 0};
    vecs[4]  = '{1, 2, 3, 1, 0, 0, 0,  1, 2};
    vecs[5]  = '{1, 2, 3, 2, 0, 0, 25, 1, 2};
    vecs[6]  = '{1, 2, 3, 3, 0, 0, 0,  0, 2};
    vecs[7]  = '{1, 2, 3, 0, 0, 0, 0,  0, 2};
    vecs[8]  = '{0, 4, 4, 0, 1, 1, 50, 0, 0};
    vecs[9]  = '{0, 1, 1, 0, 0, 1, 50, 0, 0};
    vecs[10] = '{1, 4, 4, 1, 0, 0, 0,  0, 0};
    vecs[11] = '{0, 0, 3, 0, 0, 0, 0,  0, 0};
    vecs[12] = '{0, 3, 6, 0, 0, 0, 0,  0, 0};
    vecs[13] = '{1, 1, 1, 1, 0, 0, 50, 1, 1};

    do_reset();
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_q) run_query(vecs[i].m, vecs[i].n, vecs[i].id, vecs[i].hit, vecs[i].base, vecs[i].cnt);
      else run_alloc(vecs[i].m, vecs[i].n, vecs[i].fin, 1'b0, vecs[i].ok, vecs[i].base);
    end

    // Simultaneous alloc_req and q_req: only the allocation is served.
    run_alloc(3'd5, 3'd1, 0, 1'b1, 1'b1, 75);
    run_query(3'd1, 3'd1, 3'd1, 1'b1, 50, 1);
    run_query(3'd5, 3'd1, 3'd1, 1'b1, 75, 1);

    // Fill every slot with a distinct dims pair, then request a new pair.
    do_reset();
    for (int k = 0; k < 20; k++)
      run_alloc(3'(k / 5 + 1), 3'(k % 5 + 1), 0, 1'b0, 1'b1, k * 25);
`ifdef MSA_GLOBAL_EVICT_EN
    run_alloc(3'd5, 3'd5, 0, 1'b0, 1'b1, 0);
    run_query(3'd1, 3'd1, 3'd1, 1'b0, 0, 0);
    run_query(3'd5, 3'd5, 3'd1, 1'b1, 0, 1);
`else
    begin
      int lat;
      bit seen;
      exp_q.push_back('{is_q: 1'b0, ok: 1'b0, base: 0, hit: 1'b0, cnt: 0});
      alloc_m = 3'd5;
      alloc_n = 3'd5;
      alloc_req = 1'b1;
      seen = 1'b0;
      lat = 0;
      for (int c = 1; c <= 60 && !seen; c++) begin
        @(negedge clk);
        if (addr_ready || alloc_fail) begin
          seen = 1'b1;
          lat = c;
        end
      end
      chk("full_fail_latency", lat, 22);
      repeat (4) @(negedge clk);
      chk("busy_held", busy, 1);
      alloc_req = 1'b0;
      wait_idle();
    end
    run_query(3'd5, 3'd5, 3'd1, 1'b0, 0, 0);
    run_query(3'd1, 3'd1, 3'd1, 1'b1, 0, 1);
`endif
    run_query(3'd4, 3'd5, 3'd1, 1'b1, 475, 1);

    // Reset while a grant is pending commit.
    do_reset();
    run_alloc(3'd1, 3'd2, 0, 1'b0, 1'b1, 0);
    run_alloc(3'd2, 3'd3, 2, 1'b0, 1'b1, 25);
    @(negedge clk);
    chk("pending_busy", busy, 1);
    chk("pending_base", base_addr, 25);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    run_query(3'd2, 3'd3, 3'd1, 1'b0, 0, 0);
    run_query(3'd1, 3'd2, 3'd1, 1'b0, 0, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
